// File: rtl/nibble_serial_adder.sv
// Multi-precision adder sequencer. It adds two 4*NIBBLES-bit operands one
// nibble per cycle through an external 4-bit ripple adder. The carry between
// nibbles is chained through carry_r.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic [3:0]           add_x,
    output logic [3:0]           add_y,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_r, b_r, work_r, work_nx;
    logic            carry_r;
    logic [CW-1:0]   cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state, status flags and adder drive (adder inputs are quiet outside RUN)
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        add_x    = 4'h0;
        add_y    = 4'h0;
        add_cin  = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy    = 1'b1;
                add_x   = a_r[4*int'(cnt) +: 4];
                add_y   = b_r[4*int'(cnt) +: 4];
                add_cin = carry_r;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Work vector with the current nibble merged in. The final result is taken
    // from this, so sum updates in one step and never shows partial nibbles.
    always_comb begin
        work_nx = work_r;
        work_nx[4*int'(cnt) +: 4] = add_s;
    end

    // Operand latch, nibble walk, carry chain and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            work_r  <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    work_r  <= work_nx;
                    carry_r <= add_cout;
                    if (cnt == LAST) begin
                        sum  <= work_nx;
                        cout <= add_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout;
    logic [15:0] sum;
    logic [3:0]  add_x, add_y, add_s;
    logic        add_cin, add_cout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // External 4-bit ripple adder
    assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'h0, add_cin};

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    // Present operands with start for one edge; returns at the negedge of RUN cycle 0
    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b want 0", cout); end
        vectors++; if (sum !== 16'h0000) begin miscompares++; $display("FAIL reset_sum: got %h want 0000", sum); end
        vectors++; if ({add_x, add_y, add_cin} !== 9'h0) begin miscompares++; $display("FAIL reset_add: got %h/%h/%b want 0/0/0", add_x, add_y, add_cin); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, cout, sum, add_x, add_y, add_cin} !== 28'h0) begin
                miscompares++; $display("FAIL idle_quiet[%0d]: got busy=%b done=%b sum=%h want all 0", i, busy, done, sum);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] xs [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        logic [3:0] ys [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        launch(16'h1234, 16'h4321, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            vectors++; if (add_x !== xs[i]) begin miscompares++; $display("FAIL basic_add_x[%0d]: got %h want %h", i, add_x, xs[i]); end
            vectors++; if (add_y !== ys[i]) begin miscompares++; $display("FAIL basic_add_y[%0d]: got %h want %h", i, add_y, ys[i]); end
            vectors++; if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL basic_run_flags[%0d]: got busy=%b done=%b want 1/0", i, busy, done); end
        end
        @(negedge clk);
        vectors++; if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL basic_done_flags: got busy=%b done=%b want 0/1", busy, done); end
        vectors++; if (sum !== 16'h5555) begin miscompares++; $display("FAIL basic_sum: got %h want 5555", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL basic_cout: got %b want 0", cout); end
        vectors++; if (add_x !== 4'h0) begin miscompares++; $display("FAIL basic_add_x_done: got %h want 0", add_x); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_single: got %b want 0", done); end
        vectors++; if (sum !== 16'h5555) begin miscompares++; $display("FAIL basic_sum_hold: got %h want 5555", sum); end
    endtask

    task automatic test_carry();
        logic cs [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        launch(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            vectors++; if (add_cin !== cs[i]) begin miscompares++; $display("FAIL carry_add_cin[%0d]: got %b want %b", i, add_cin, cs[i]); end
            vectors++; if (sum !== 16'h5555) begin miscompares++; $display("FAIL carry_no_partial[%0d]: got %h want 5555", i, sum); end
        end
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL carry_done: got %b want 1", done); end
        vectors++; if (sum !== 16'h0000) begin miscompares++; $display("FAIL carry_sum: got %h want 0000", sum); end
        vectors++; if (cout !== 1'b1) begin miscompares++; $display("FAIL carry_cout: got %b want 1", cout); end
    endtask

    task automatic test_back_to_back();
        launch(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (4) @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done1: got %b want 1", done); end
        vectors++; if ({cout, sum} !== 17'h1FFFF) begin miscompares++; $display("FAIL b2b_result1: got %b/%h want 1/ffff", cout, sum); end
        // start presented during the DONE cycle
        a = 16'h0000; b = 16'h0000; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        repeat (3) @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_early_done: got %b want 0", done); end
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done2: got %b want 1", done); end
        vectors++; if ({cout, sum} !== 17'h00001) begin miscompares++; $display("FAIL b2b_result2: got %b/%h want 0/0001", cout, sum); end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        launch(16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (add_x !== 4'hF) begin miscompares++; $display("FAIL ignore_add_x: got %h want f", add_x); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                vectors++; if ({cout, sum} !== 17'h01010) begin miscompares++; $display("FAIL ignore_result: got %b/%h want 0/1010", cout, sum); end
            end
        end
        vectors++; if (ndone != 1) begin miscompares++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_reset_midop();
        launch(16'h8000, 16'h8000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if ({busy, done, cout} !== 3'b000) begin miscompares++; $display("FAIL midrst_flags: got busy=%b done=%b cout=%b want 0", busy, done, cout); end
        vectors++; if (sum !== 16'h0000) begin miscompares++; $display("FAIL midrst_sum: got %h want 0000", sum); end
        vectors++; if ({add_x, add_y, add_cin} !== 9'h0) begin miscompares++; $display("FAIL midrst_add: got %h/%h/%b want 0", add_x, add_y, add_cin); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done[%0d]: got %b want 0", i, done); end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_post_release: got %b want 0", done); end
        launch(16'h0002, 16'h0003, 1'b0);
        repeat (4) @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL midrst_done: got %b want 1", done); end
        vectors++; if ({cout, sum} !== 17'h00005) begin miscompares++; $display("FAIL midrst_result: got %b/%h want 0/0005", cout, sum); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
